// File: rtl/subword_lane_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module      : subword_lane_unit                                            |
// | Description : Combined byte/halfword lane unit for the multi-cycle MIPS    |
// |               datapath. Extracts a byte or halfword lane from a 32-bit     |
// |               memory word with sign/zero extension (LB/LBU/LH/LHU), or     |
// |               merges a register byte/halfword into the word (SB/SH         |
// |               read-modify-write). Results are offered combinationally and  |
// |               as a one-cycle registered copy. Little-endian lane order.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
//
// Ports:
//   clk        in   1   clock; registered outputs update on the rising edge
//   reset      in   1   asynchronous, active-high; clears the registered outputs
//   word_in    in  32   memory word (load data, or old word for a merge)
//   by_pos     in   4   byte control     {signed, write, lane[1:0]}
//   hl_pos     in   3   halfword control {signed, write, lane}
//   rt_byte    in   8   register byte to store (rt[7:0])
//   rt_half    in  16   register halfword to store (rt[15:0])
//   result_b   out 32   byte-path result, combinational
//   result_h   out 32   halfword-path result, combinational
//   result_b_q out 32   result_b registered
//   result_h_q out 32   result_h registered
//------------------------------------------------------------------------------
module subword_lane_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] word_in,
   input  logic [3:0]  by_pos,
   input  logic [2:0]  hl_pos,
   input  logic [7:0]  rt_byte,
   input  logic [15:0] rt_half,
   output logic [31:0] result_b,
   output logic [31:0] result_h,
   output logic [31:0] result_b_q,
   output logic [31:0] result_h_q
);

   // Control field positions
   localparam int unsigned C_BY_SIGNED = 3;
   localparam int unsigned C_BY_WRITE  = 2;
   localparam int unsigned C_HL_SIGNED = 2;
   localparam int unsigned C_HL_WRITE  = 1;
   localparam int unsigned C_HL_LANE   = 0;

   logic [1:0]  w_by_lane;
   logic        w_by_signed;
   logic        w_by_write;
   logic        w_hl_lane;
   logic        w_hl_signed;
   logic        w_hl_write;

   logic [7:0]  w_byte_sel;
   logic [31:0] w_byte_merge;
   logic [15:0] w_half_sel;
   logic [31:0] w_half_merge;

   logic [31:0] r_result_b;
   logic [31:0] r_result_h;

   assign w_by_lane   = by_pos[1:0];
   assign w_by_signed = by_pos[C_BY_SIGNED];
   assign w_by_write  = by_pos[C_BY_WRITE];
   assign w_hl_lane   = hl_pos[C_HL_LANE];
   assign w_hl_signed = hl_pos[C_HL_SIGNED];
   assign w_hl_write  = hl_pos[C_HL_WRITE];

   //---------------------------------------------------------------------------
   // Byte path
   //---------------------------------------------------------------------------
   // Lane select for extraction; depends only on word_in and the lane bits.
   always_comb begin
      w_byte_sel = word_in[7:0];
      case (w_by_lane)
         2'd0:    w_byte_sel = word_in[7:0];
         2'd1:    w_byte_sel = word_in[15:8];
         2'd2:    w_byte_sel = word_in[23:16];
         default: w_byte_sel = word_in[31:24];
      endcase
   end

   // Read-modify-write: replace one byte lane with the register byte.
   always_comb begin
      w_byte_merge = word_in;
      case (w_by_lane)
         2'd0:    w_byte_merge[7:0]   = rt_byte;
         2'd1:    w_byte_merge[15:8]  = rt_byte;
         2'd2:    w_byte_merge[23:16] = rt_byte;
         default: w_byte_merge[31:24] = rt_byte;
      endcase
   end

   // The mode decision is a full if/else so that, with a known control word,
   // the rt_byte-dependent merge value never reaches an extract result.
   always_comb begin
      result_b = {24'b0, w_byte_sel};
      if (w_by_write) begin
         result_b = w_byte_merge;
      end else if (w_by_signed) begin
         result_b = {{24{w_byte_sel[7]}}, w_byte_sel};
      end else begin
         result_b = {24'b0, w_byte_sel};
      end
   end

   //---------------------------------------------------------------------------
   // Halfword path
   //---------------------------------------------------------------------------
   always_comb begin
      w_half_sel = word_in[15:0];
      if (w_hl_lane) begin
         w_half_sel = word_in[31:16];
      end
   end

   always_comb begin
      w_half_merge = word_in;
      if (w_hl_lane) begin
         w_half_merge[31:16] = rt_half;
      end else begin
         w_half_merge[15:0]  = rt_half;
      end
   end

   always_comb begin
      result_h = {16'b0, w_half_sel};
      if (w_hl_write) begin
         result_h = w_half_merge;
      end else if (w_hl_signed) begin
         result_h = {{16{w_half_sel[15]}}, w_half_sel};
      end else begin
         result_h = {16'b0, w_half_sel};
      end
   end

   //---------------------------------------------------------------------------
   // Registered copies for the following stage
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_result_b <= 32'h0;
         r_result_h <= 32'h0;
      end else begin
         r_result_b <= result_b;
         r_result_h <= result_h;
      end
   end

   assign result_b_q = r_result_b;
   assign result_h_q = r_result_h;

endmodule
`default_nettype wire

// File: tb/tb_subword_lane_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module      : tb_subword_lane_unit                                         |
// | Description : Directed testbench for subword_lane_unit: byte/halfword      |
// |               extract and merge vectors, idle encoding, registered copy    |
// |               latency and asynchronous reset behaviour.                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module tb_subword_lane_unit;

   logic        clk;
   logic        reset;
   logic [31:0] word_in;
   logic [3:0]  by_pos;
   logic [2:0]  hl_pos;
   logic [7:0]  rt_byte;
   logic [15:0] rt_half;
   logic [31:0] result_b;
   logic [31:0] result_h;
   logic [31:0] result_b_q;
   logic [31:0] result_h_q;

   int n_total;
   int n_pass;

   subword_lane_unit dut (
      .clk        (clk),
      .reset      (reset),
      .word_in    (word_in),
      .by_pos     (by_pos),
      .hl_pos     (hl_pos),
      .rt_byte    (rt_byte),
      .rt_half    (rt_half),
      .result_b   (result_b),
      .result_h   (result_h),
      .result_b_q (result_b_q),
      .result_h_q (result_h_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
   endtask

   task automatic check_known(input string tag, input logic [31:0] obs);
      n_total++;
      assert (!$isunknown(obs)) n_pass++;
      else $error("FAIL %s: observed %08h expected no X/Z", tag, obs);
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      reset   = 1'b1;
      word_in = 32'h0;
      by_pos  = 4'b0;
      hl_pos  = 3'b0;
      rt_byte = 8'h0;
      rt_half = 16'h0;

      // Reset state of the registered copies
      #2;
      check("rst_b_q", result_b_q, 32'h0);
      check("rst_h_q", result_h_q, 32'h0);

      // Byte extract, unsigned then signed, all lanes
      word_in = 32'h8899AA7F;
      by_pos = 4'b0000; #1; check("lbu_l0", result_b, 32'h0000007F);
      by_pos = 4'b0001; #1; check("lbu_l1", result_b, 32'h000000AA);
      by_pos = 4'b0010; #1; check("lbu_l2", result_b, 32'h00000099);
      by_pos = 4'b0011; #1; check("lbu_l3", result_b, 32'h00000088);
      by_pos = 4'b1000; #1; check("lb_l0",  result_b, 32'h0000007F);
      by_pos = 4'b1001; #1; check("lb_l1",  result_b, 32'hFFFFFFAA);
      by_pos = 4'b1010; #1; check("lb_l2",  result_b, 32'hFFFFFF99);
      by_pos = 4'b1011; #1; check("lb_l3",  result_b, 32'hFFFFFF88);

      // Halfword extract
      word_in = 32'h80017FFE;
      hl_pos = 3'b000; #1; check("lhu_l0", result_h, 32'h00007FFE);
      hl_pos = 3'b100; #1; check("lh_l0",  result_h, 32'h00007FFE);
      hl_pos = 3'b001; #1; check("lhu_l1", result_h, 32'h00008001);
      hl_pos = 3'b101; #1; check("lh_l1",  result_h, 32'hFFFF8001);

      // Byte merge
      word_in = 32'h11223344;
      rt_byte = 8'hAB;
      by_pos = 4'b0100; #1; check("sb_l0",     result_b, 32'h112233AB);
      by_pos = 4'b0101; #1; check("sb_l1",     result_b, 32'h1122AB44);
      by_pos = 4'b0110; #1; check("sb_l2",     result_b, 32'h11AB3344);
      by_pos = 4'b0111; #1; check("sb_l3",     result_b, 32'hAB223344);
      by_pos = 4'b1110; #1; check("sb_l2_sgn", result_b, 32'h11AB3344);

      // Halfword merge
      rt_half = 16'hBEEF;
      hl_pos = 3'b010; #1; check("sh_l0",     result_h, 32'h1122BEEF);
      hl_pos = 3'b011; #1; check("sh_l1",     result_h, 32'hBEEF3344);
      hl_pos = 3'b111; #1; check("sh_l1_sgn", result_h, 32'hBEEF3344);

      // Idle encoding with unused register inputs undriven
      word_in = 32'hCAFEF00D;
      by_pos  = 4'b0000;
      hl_pos  = 3'b000;
      rt_byte = 'x;
      rt_half = 'x;
      #1;
      check("idle_b", result_b, 32'h0000000D);
      check("idle_h", result_h, 32'h0000F00D);
      check_known("idle_b_known", result_b);
      check_known("idle_h_known", result_h);
      check_known("idle_bq_known", result_b_q);
      check_known("idle_hq_known", result_h_q);

      // Registers stayed cleared while reset was held across edges
      check("hold_rst_b_q", result_b_q, 32'h0);

      // Registered path: release reset, load a sign-extending byte/half
      rt_byte = 8'h00;
      rt_half = 16'h0000;
      @(negedge clk);
      reset   = 1'b0;
      word_in = 32'h80000000;
      by_pos  = 4'b1011;
      hl_pos  = 3'b101;
      #1;
      check("pre_edge_b_q", result_b_q, 32'h0);
      @(posedge clk); #1;
      check("reg_b_q", result_b_q, 32'hFFFFFF80);
      check("reg_h_q", result_h_q, 32'hFFFF8000);

      // One-edge latency: change inputs, copy holds until the next edge
      by_pos = 4'b0000;
      hl_pos = 3'b000;
      #1;
      check("comb_b_now", result_b, 32'h00000000);
      check("lat_hold_b_q", result_b_q, 32'hFFFFFF80);
      @(posedge clk); #1;
      check("lat_next_b_q", result_b_q, 32'h00000000);
      check("lat_next_h_q", result_h_q, 32'h00000000);

      by_pos = 4'b1011;
      hl_pos = 3'b101;
      @(posedge clk); #1;
      check("reload_b_q", result_b_q, 32'hFFFFFF80);

      // Asynchronous reset mid-cycle clears before the next edge
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_b_q", result_b_q, 32'h0);
      check("async_rst_h_q", result_h_q, 32'h0);
      check("rst_comb_b", result_b, 32'hFFFFFF80);
      @(posedge clk); #1;
      check("rst_held_b_q", result_b_q, 32'h0);

      // Release reset mid-cycle; the next edge reloads current values
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rel_pre_b_q", result_b_q, 32'h0);
      @(posedge clk); #1;
      check("rel_b_q", result_b_q, 32'hFFFFFF80);
      check("rel_h_q", result_h_q, 32'hFFFF8000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
